uart_tx_fifo: RTL and testbench

8N1 UART transmitter, the transmit-side counterpart to the existing Uart8 receive path. It accepts bytes over a ready/valid push interface into a small FIFO. It serialises each byte LSB-first on tx at BAUD_RATE, with the bit clock derived from CLOCK_RATE. It sits between the host logic and the serial pin; its output wires directly to a receiver's rx line.

---
 rtl/uart_tx_fifo.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small push FIFO.
// Outputs follow the state register by one cycle, so tx/txBusy/txDone line up with the serial frame.
module uart_tx_fifo #(
    parameter int CLOCK_RATE = 12000000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       txEn,
    input  logic       txStart,
    input  logic [7:0] in,
    output logic       txReady,
    output logic       txBusy,
    output logic       txDone,
    output logic       tx
);
    localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [PW:0]   FIFO_FULL = (PW+1)'(FIFO_DEPTH);

    if (CLKS_PER_BIT < 2) begin : g_bad_rate
        $error("uart_tx_fifo: CLOCK_RATE/BAUD_RATE must be at least 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]     count_q, count_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic            tx_q, tx_d, busy_q, busy_d, done_q, done_d;
    logic            push_s, pop_s, baud_end_s;

    // Next-state, FIFO bookkeeping and the one-cycle-delayed line outputs.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        count_d    = count_q;
        mem_d      = mem_q;
        tx_d       = 1'b1;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        pop_s      = 1'b0;
        push_s     = txStart && (count_q != FIFO_FULL);
        baud_end_s = (baud_q == BAUD_LAST);

        case (state_q)
            IDLE: begin
                if (txEn && (count_q != '0)) begin
                    pop_s   = 1'b1;
                    shift_d = mem_q[rd_q];
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                tx_d   = 1'b0;
                busy_d = 1'b1;
                if (baud_end_s) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                tx_d   = shift_q[0];
                busy_d = 1'b1;
                if (baud_end_s) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                busy_d = 1'b1;
                if (baud_end_s) begin
                    baud_d = '0;
                    // bit_q reused to count stop bits
                    if (bit_q == STOP_LAST) begin
                        bit_d   = 3'd0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (push_s) begin
            mem_d[wr_q] = in;
            wr_d        = wr_q + 1'b1;
        end else begin
            wr_d = wr_q;
        end
        if (pop_s) begin
            rd_d = rd_q + 1'b1;
        end else begin
            rd_d = rd_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State, FIFO and output registers; reset forces the line idle immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            mem_q   <= '{default: 8'h00};
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            mem_q   <= mem_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign txReady = (count_q != FIFO_FULL);
    assign txBusy  = busy_q;
    assign txDone  = done_q;
    assign tx      = tx_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 4 clocks per bit with 2 stop bits (44-cycle frames).
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int SB    = 2;
    localparam int FRAME = (9 + SB) * CPB;

    logic       clk = 1'b0;
    logic       reset, txEn, txStart;
    logic [7:0] in;
    logic       txReady, txBusy, txDone, tx;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;

    // Frame records: frame bit i is the line level during bit cell i (start at bit 0).
    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;
    } vec_t;
    vec_t tbl [10];

    uart_tx_fifo #(
        .CLOCK_RATE(16), .BAUD_RATE(4), .FIFO_DEPTH(4), .STOP_BITS(SB)
    ) dut (
        .clk(clk), .reset(reset), .txEn(txEn), .txStart(txStart), .in(in),
        .txReady(txReady), .txBusy(txBusy), .txDone(txDone), .tx(tx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (txDone === 1'b1) done_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        txStart = 1'b1;
        in      = b;
        @(negedge clk);
        txStart = 1'b0;
        in      = ~b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("idle tx", tx, 1);
            chk("idle busy", txBusy, 0);
            chk("idle done", txDone, 0);
        end
    endtask

    // Wait (bounded) for the start bit, then check every cycle of the frame.
    task automatic frame(input logic [10:0] exp, input int lat, input int drop_at, input int rst_at);
        int k = 0;
        while (tx !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("start latency", k, lat);
        if (k >= 200) return;
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge clk);
            if (i == rst_at) begin
                reset = 1'b1;
                #1;
                chk("reset tx", tx, 1);
                chk("reset busy", txBusy, 0);
                chk("reset done", txDone, 0);
                chk("reset ready", txReady, 1);
                return;
            end
            chk("frame tx", tx, exp[i / CPB]);
            chk("frame busy", txBusy, 1);
            chk("frame done", txDone, (i == FRAME - 1) ? 1 : 0);
            if (i == drop_at) txEn = 1'b0;
        end
    endtask

    initial begin
        int d0;
        tbl[0] = '{8'h35, 11'b11_00110101_0};
        tbl[1] = '{8'h80, 11'b11_10000000_0};
        tbl[2] = '{8'h00, 11'b11_00000000_0};
        tbl[3] = '{8'hFF, 11'b11_11111111_0};
        tbl[4] = '{8'h01, 11'b11_00000001_0};
        tbl[5] = '{8'h02, 11'b11_00000010_0};
        tbl[6] = '{8'h04, 11'b11_00000100_0};
        tbl[7] = '{8'h08, 11'b11_00001000_0};
        tbl[8] = '{8'hA5, 11'b11_10100101_0};
        tbl[9] = '{8'h5A, 11'b11_01011010_0};

        reset = 1'b1; txEn = 1'b0; txStart = 1'b0; in = 8'h00;
        repeat (10) @(negedge clk);
        chk("rst tx", tx, 1);
        chk("rst busy", txBusy, 0);
        chk("rst done", txDone, 0);
        chk("rst ready", txReady, 1);
        reset = 1'b0;
        idle(100);
        chk("post-rst ready", txReady, 1);

        // Single frames from an empty FIFO.
        txEn = 1'b1;
        for (int e = 0; e < 4; e++) begin
            push(tbl[e].data);
            frame(tbl[e].frame, 2, -1, -1);
            idle(3);
        end

        // Fill with txEn low: fifth push is dropped, then drain back-to-back.
        txEn = 1'b0;
        for (int j = 0; j < 5; j++) begin
            chk("fill ready", txReady, (j < 4) ? 1 : 0);
            txStart = 1'b1;
            in      = (j < 4) ? tbl[4 + j].data : 8'h10;
            @(negedge clk);
        end
        txStart = 1'b0;
        chk("full ready", txReady, 0);
        idle(10);
        chk("held full ready", txReady, 0);
        d0   = done_cnt;
        txEn = 1'b1;
        @(negedge clk);
        chk("ready after pop", txReady, 1);
        frame(tbl[4].frame, 1, -1, -1);
        for (int j = 5; j < 8; j++) frame(tbl[j].frame, 2, -1, -1);
        idle(60);
        chk("done pulses", done_cnt - d0, 4);

        // Drop txEn mid-frame with a byte queued.
        txEn = 1'b1;
        push(tbl[8].data);
        push(tbl[9].data);
        frame(tbl[8].frame, 1, 12, -1);
        idle(60);
        chk("queued ready", txReady, 1);
        txEn = 1'b1;
        frame(tbl[9].frame, 2, -1, -1);
        idle(5);

        // Reset mid-data of 0xFF with two bytes queued.
        push(tbl[3].data);
        push(8'h11);
        push(8'h22);
        frame(tbl[3].frame, 0, -1, 20);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(60);
        chk("post-abort ready", txReady, 1);

        // Reset during the start bit: the line must rise without a clock edge.
        push(tbl[0].data);
        frame(tbl[0].frame, 2, -1, 2);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
